tx_prbs_modulator: RTL and testbench

//  Transmit-side counterpart of the receive chain: generates one of the 16 pseudo-random binary

---
 rtl/tx_prbs_modulator_if.sv | 25 ++
 rtl/tx_prbs_modulator.sv | 114 +++++++++++
 tb/tb_tx_prbs_modulator.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/tx_prbs_modulator_if.sv
// tx_prbs_modulator_if: control and sample-stream bundle of the PRBS BPSK transmitter.
//   etx_en          enable; low aborts any transmission
//   istart          start request, sampled while idle
//   iseq_sel[3:0]   sequence index, captured on an accepted start
//   otx_sample[15:0] signed modulated sample
//   otx_sample_trig one-clock strobe when otx_sample is new
//   obusy           high while transmitting
//   odone           one-clock pulse at the end of a complete transmission
interface tx_prbs_modulator_if;
    logic               etx_en;
    logic               istart;
    logic [3:0]         iseq_sel;
    logic signed [15:0] otx_sample;
    logic               otx_sample_trig;
    logic               obusy;
    logic               odone;
    modport master (
        output etx_en, istart, iseq_sel,
        input  otx_sample, otx_sample_trig, obusy, odone
    );
    modport slave (
        input  etx_en, istart, iseq_sel,
        output otx_sample, otx_sample_trig, obusy, odone
    );
endinterface

// File: rtl/tx_prbs_modulator.sv
// tx_prbs_modulator: 9-bit PRBS (x^9+x^5+1) BPSK-modulated onto an fs/8 sampled carrier.
//   ctx_clk  clock
//   rtx_rst  asynchronous active-low reset
//   tx       slave side of tx_prbs_modulator_if (enable/start/select in, sample stream out)
module tx_prbs_modulator #(
    parameter int CLKS_PER_SAMPLE  = 128,
    parameter int SAMPLES_PER_CHIP = 32,
    parameter int SEQ_LEN          = 511,
    parameter int AMPLITUDE        = 16384
) (
    input logic                ctx_clk,
    input logic                rtx_rst,
    tx_prbs_modulator_if.slave tx
);
    localparam int N  = SEQ_LEN * SAMPLES_PER_CHIP;
    localparam int TW = $clog2(CLKS_PER_SAMPLE + 1);
    localparam int CW = $clog2(SAMPLES_PER_CHIP + 1);
    localparam int SW = $clog2(N + 1);
    localparam logic signed [15:0] AMP  = 16'(AMPLITUDE);
    // round(AMPLITUDE*sqrt(0.5)) using sqrt(0.5) scaled by 2^31
    localparam logic signed [15:0] DIAG = 16'((64'(AMPLITUDE) * 64'd1518500250 + 64'd1073741824) >> 31);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [8:0]         lfsr_q, lfsr_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [CW-1:0]      chip_q, chip_d;
    logic [SW-1:0]      samp_q, samp_d;
    logic [2:0]         phase_q, phase_d;
    logic signed [15:0] sample_q, sample_d, mag;
    logic               trig_q, trig_d, done_q, done_d;
    logic               start, emit, fin, last;

    assign start = state_q == IDLE && tx.istart;
    assign emit  = state_q == RUN && tick_q == '0 && samp_q != SW'(N);
    assign fin   = state_q == RUN && tick_q == '0 && samp_q == SW'(N);
    assign last  = chip_q == CW'(SAMPLES_PER_CHIP - 1);
    // First-quadrant magnitude; the sign comes from phase[2] xor chip
    assign mag   = phase_q[1:0] == 2'd0 ? 16'sd0 : phase_q[1:0] == 2'd2 ? AMP : DIAG;

    always_ff @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            state_q  <= IDLE;
            lfsr_q   <= '0;
            tick_q   <= '0;
            chip_q   <= '0;
            samp_q   <= '0;
            phase_q  <= '0;
            sample_q <= '0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            tick_q   <= tick_d;
            chip_q   <= chip_d;
            samp_q   <= samp_d;
            phase_q  <= phase_d;
            sample_q <= sample_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
        end
    end

    always_comb state_d = !tx.etx_en ? IDLE : start ? RUN : fin ? IDLE : state_q;

    always_comb begin
        lfsr_d   = lfsr_q;
        tick_d   = tick_q;
        chip_d   = chip_q;
        samp_d   = samp_q;
        phase_d  = phase_q;
        sample_d = sample_q;
        trig_d   = 1'b0;
        done_d   = 1'b0;
        if (!tx.etx_en) begin
            lfsr_d   = '0;
            tick_d   = '0;
            chip_d   = '0;
            samp_d   = '0;
            phase_d  = '0;
            sample_d = '0;
        end else if (start) begin
            lfsr_d  = {tx.iseq_sel, 5'b00001};
            tick_d  = '0;
            chip_d  = '0;
            samp_d  = '0;
            phase_d = '0;
        end else if (fin) begin
            done_d   = 1'b1;
            sample_d = '0;
            chip_d   = '0;
            samp_d   = '0;
            phase_d  = '0;
        end else if (state_q == RUN) begin
            tick_d = tick_q == TW'(CLKS_PER_SAMPLE - 1) ? '0 : tick_q + 1'b1;
            if (emit) begin
                trig_d   = 1'b1;
                sample_d = (phase_q[2] ^ lfsr_q[0]) ? -mag : mag;
                phase_d  = phase_q + 1'b1;
                samp_d   = samp_q + 1'b1;
                chip_d   = last ? '0 : chip_q + 1'b1;
                // Shift toward bit 0 so lfsr[0] is the current chip
                lfsr_d   = last ? {lfsr_q[0] ^ lfsr_q[4], lfsr_q[8:1]} : lfsr_q;
            end
        end
    end

    assign tx.otx_sample      = sample_q;
    assign tx.otx_sample_trig = trig_q;
    assign tx.obusy           = state_q == RUN;
    assign tx.odone           = done_q;
endmodule

// File: tb/tb_tx_prbs_modulator.sv
// tb_tx_prbs_modulator: randomized, model-checked bench for tx_prbs_modulator.
module tb_tx_prbs_modulator;
    localparam int CPS = 3;
    localparam int SPC = 8;
    localparam int SL  = 511;
    localparam int AMP = 16384;
    localparam int NS  = SL * SPC;

    logic ctx_clk = 1'b0;
    logic rtx_rst = 1'b0;
    tx_prbs_modulator_if bus ();

    tx_prbs_modulator #(
        .CLKS_PER_SAMPLE(CPS), .SAMPLES_PER_CHIP(SPC), .SEQ_LEN(SL), .AMPLITUDE(AMP)
    ) dut (
        .ctx_clk(ctx_clk),
        .rtx_rst(rtx_rst),
        .tx(bus)
    );

    always #5 ctx_clk = ~ctx_clk;

    int errors = 0;
    int checks = 0;

    bit seqs[16][SL];
    int lutv[8];

    logic signed [15:0] e_samp;
    logic               e_trig, e_busy, e_done, m_run;
    int                 rel, msel;

    function automatic int samp_of(input int s, input int n);
        int v;
        v = lutv[n % 8];
        return seqs[s][n / SPC] ? -v : v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: acceptance at relative edge 0, sample n at edge 1+n*CPS, end at 1+NS*CPS
    always @(posedge ctx_clk or negedge rtx_rst) begin
        if (!rtx_rst) begin
            m_run  <= 1'b0;
            rel    <= 0;
            msel   <= 0;
            e_samp <= '0;
            e_trig <= 1'b0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
        end else begin
            e_trig <= 1'b0;
            e_done <= 1'b0;
            if (!bus.etx_en) begin
                m_run  <= 1'b0;
                e_samp <= '0;
                e_busy <= 1'b0;
            end else if (!m_run) begin
                if (bus.istart) begin
                    m_run  <= 1'b1;
                    rel    <= 0;
                    msel   <= int'(bus.iseq_sel);
                    e_busy <= 1'b1;
                end
            end else begin
                rel <= rel + 1;
                if (rel + 1 == 1 + NS * CPS) begin
                    m_run  <= 1'b0;
                    e_busy <= 1'b0;
                    e_done <= 1'b1;
                    e_samp <= '0;
                end else if (rel % CPS == 0) begin
                    e_trig <= 1'b1;
                    e_samp <= 16'(samp_of(msel, rel / CPS));
                end
            end
        end
    end

    always @(negedge ctx_clk) begin
        checks++;
        if ({bus.otx_sample, bus.otx_sample_trig, bus.obusy, bus.odone} !== {e_samp, e_trig, e_busy, e_done}) begin
            errors++;
            $display("FAIL stream: got sample=%0d trig=%b busy=%b done=%b expected sample=%0d trig=%b busy=%b done=%b at %0t",
                     bus.otx_sample, bus.otx_sample_trig, bus.obusy, bus.odone, e_samp, e_trig, e_busy, e_done, $time);
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    task automatic start_tx(input int s);
        @(negedge ctx_clk);
        #1;
        bus.etx_en   = 1'b1;
        bus.iseq_sel = 4'(s);
        bus.istart   = 1'b1;
        @(negedge ctx_clk);
        #1;
        bus.istart   = 1'b0;
        bus.iseq_sel = 4'($urandom_range(15));
    endtask

    task automatic wait_trig(output int n);
        n = 0;
        do begin
            @(negedge ctx_clk);
            n++;
        end while (!bus.otx_sample_trig && n < 4 * CPS + 4);
        if (!bus.otx_sample_trig) chk("trig_timeout", 0, 1);
    endtask

    task automatic wait_done(output int n, output int t);
        n = 0;
        t = 0;
        do begin
            @(negedge ctx_clk);
            n++;
            if (bus.otx_sample_trig) t++;
        end while (!bus.odone && n < NS * CPS + 50);
        if (!bus.odone) chk("done_timeout", 0, 1);
    endtask

    task automatic abort_tx();
        #1;
        bus.etx_en = 1'b0;
        @(negedge ctx_clk);
    endtask

    initial begin
        int n, t, same;
        int exp2[8] = '{0, -11585, -16384, -11585, 0, 11585, 16384, 11585};
        bit [8:0] seed;
        real r;
        bus.etx_en   = 1'b0;
        bus.istart   = 1'b0;
        bus.iseq_sel = 4'd0;
        for (int p = 0; p < 8; p++) begin
            r = AMP * $sin(2.0 * 3.14159265358979 * p / 8.0);
            lutv[p] = r >= 0.0 ? $rtoi(r + 0.5) : -$rtoi(-r + 0.5);
        end
        for (int s = 0; s < 16; s++) begin
            seed = 9'(s * 32 + 1);
            for (int i = 0; i < 9; i++) seqs[s][i] = seed[i];
            for (int i = 9; i < SL; i++) seqs[s][i] = seqs[s][i-9] ^ seqs[s][i-5];
        end
        chk("model_lut1", lutv[1], 11585);
        chk("model_lut6", lutv[6], -16384);
        chk("model_lut4", lutv[4], 0);
        chk("model_chip_s0_9", int'(seqs[0][9]), 1);
        chk("model_samp_s0_2", samp_of(0, 2), -16384);
        same = 0;
        for (int a = 0; a < 16; a++)
            for (int b = a + 1; b < 16; b++)
                if (seqs[a] == seqs[b]) same++;
        chk("distinct_streams", same, 0);

        repeat (3) @(negedge ctx_clk);
        #1 rtx_rst = 1'b1;
        @(negedge ctx_clk);
        chk("post_reset_busy", int'(bus.obusy), 0);
        chk("post_reset_trig", int'(bus.otx_sample_trig), 0);

        start_tx(0);
        wait_trig(n);
        chk("first_trig_latency", n, 1);
        chk("sel0_sample0", int'(bus.otx_sample), exp2[0]);
        for (int i = 1; i < 8; i++) begin
            wait_trig(n);
            chk("trig_spacing", n, CPS);
            chk($sformatf("sel0_sample%0d", i), int'(bus.otx_sample), exp2[i]);
        end

        #2 rtx_rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({bus.otx_sample, bus.otx_sample_trig, bus.obusy, bus.odone}), 0);
        repeat (2) @(negedge ctx_clk);
        #1 rtx_rst = 1'b1;
        @(negedge ctx_clk);
        chk("reset_release_busy", int'(bus.obusy), 0);
        chk("reset_release_trig", int'(bus.otx_sample_trig), 0);

        #1;
        bus.etx_en = 1'b0;
        bus.istart = 1'b1;
        @(negedge ctx_clk);
        chk("disabled_start_ignored", int'(bus.obusy), 0);
        #1 bus.istart = 1'b0;

        start_tx(3);
        for (int i = 0; i <= 1000; i++) wait_trig(n);
        abort_tx();
        chk("abort_outputs", int'({bus.otx_sample, bus.otx_sample_trig, bus.obusy, bus.odone}), 0);

        start_tx(3);
        wait_trig(n);
        chk("restart_latency", n, 1);
        chk("restart_sample0", int'(bus.otx_sample), samp_of(3, 0));
        for (int i = 0; i < 3; i++) wait_trig(n);
        #1;
        bus.istart   = 1'b1;
        bus.iseq_sel = 4'd9;
        wait_done(n, t);
        chk("held_start_no_restart", t, NS - 4);
        @(negedge ctx_clk);
        chk("start_after_done", int'(bus.obusy), 1);
        #1 bus.istart = 1'b0;
        wait_trig(n);
        chk("after_done_latency", n, 1);
        abort_tx();

        start_tx(5);
        wait_done(n, t);
        chk("full_run_trigs", t, NS);
        chk("full_run_done_edge", n, 1 + NS * CPS);
        chk("full_run_busy_fall", int'(bus.obusy), 0);
        @(negedge ctx_clk);
        chk("done_one_cycle", int'(bus.odone), 0);

        for (int s = 0; s < 16; s++) begin
            start_tx(s);
            for (int i = 0; i < 10 + int'($urandom_range(8)); i++) wait_trig(n);
            abort_tx();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
